// File: rtl/input_port_ctrl.sv
// Push-button input port: synchronise and debounce the button, capture the switch word
// into a small FIFO on each press, and present the head word to the bus.
module input_port_ctrl #(
    parameter int DW              = 32,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn,
    input  logic [DW-1:0]            sw,
    input  logic                     rd_ack,
    input  logic                     clr_ovr,
    output logic                     is_ready,
    output logic [DW-1:0]            data_input,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] CNT_MAX = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic           s1_q, s2_q;
    logic           stable_q, stable_d;
    logic           stable_prev_q;
    logic [DBW-1:0] cnt_q, cnt_d;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [DW-1:0]  data_q, data_d;
    logic           overrun_q, overrun_d;
    logic [DW-1:0]  mem [DEPTH];

    logic push, pop, full, do_write, drop;

    // Synchroniser, debounce state and press-edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            s1_q          <= btn;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign push     = stable_q & ~stable_prev_q;
    assign full     = (count_q == CNT_FULL);
    assign pop      = rd_ack & (count_q != '0);
    assign do_write = push & (~full | pop);
    assign drop     = push & full & ~pop;

    always_comb begin
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        wr_ptr_d  = wr_ptr_q + AW'(do_write);
        count_d   = count_q + CW'(do_write) - CW'(pop);
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        // The new head is either the word being written into the head slot this cycle,
        // the next stored entry after a pop, or unchanged (including when the pop empties).
        data_d = data_q;
        if (do_write && (wr_ptr_q == rd_ptr_d)) begin
            data_d = sw;
        end else if (pop && (count_q != CNT_ONE)) begin
            data_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (do_write && (wr_ptr_q == AW'(gi))) begin
                    mem[gi] <= sw;
                end
            end
        end
    endgenerate

    assign is_ready   = (count_q != '0);
    assign data_input = data_q;
    assign count      = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl: debounce latency, glitch rejection, FIFO order,
// overrun, simultaneous push/pop, empty-pop and asynchronous reset.
module tb_input_port_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn;
    logic [DW-1:0] sw;
    logic          rd_ack;
    logic          clr_ovr;
    logic          is_ready;
    logic [DW-1:0] data_input;
    logic [2:0]    count;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    input_port_ctrl #(.DW(DW), .DEPTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .sw         (sw),
        .rd_ack     (rd_ack),
        .clr_ovr    (clr_ovr),
        .is_ready   (is_ready),
        .data_input (data_input),
        .count      (count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press with btn held 8 cycles; optionally hold rd_ack on the push edge (edge 6).
    task automatic press(input logic [DW-1:0] v, input logic ack_on_push);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        cycles(6);
        rd_ack = ack_on_push;
        cycles(1);
        rd_ack = 1'b0;
        cycles(1);
        btn = 1'b0;
        cycles(8);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; sw = '0; rd_ack = 1'b0; clr_ovr = 1'b0;
        cycles(3);
        check("rst_ready", is_ready, 0);
        check("rst_count", count, 0);
        check("rst_data", data_input, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        cycles(2);

        // 1: single press latency and pop
        sw = 32'h1; btn = 1'b1;
        cycles(6);
        check("t1_not_yet", is_ready, 0);
        cycles(1);
        check("t1_ready", is_ready, 1);
        check("t1_data", data_input, 32'h1);
        check("t1_count", count, 1);
        cycles(13);
        btn = 1'b0;
        cycles(8);
        pop_one();
        check("t1_pop_ready", is_ready, 0);
        check("t1_pop_count", count, 0);
        check("t1_pop_data", data_input, 32'h1);

        // 2: glitch rejection
        sw = 32'hA; btn = 1'b1; cycles(3); btn = 1'b0; cycles(8);
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1; cycles(2); btn = 1'b0; cycles(2);
        end
        cycles(8);
        check("t2_glitch_cnt", count, 0);
        check("t2_glitch_rdy", is_ready, 0);
        press(32'hA, 1'b0);
        check("t2_one_push", count, 1);
        check("t2_data", data_input, 32'hA);
        pop_one();
        check("t2_drained", count, 0);

        // 3: order, overrun, wrap
        for (int i = 1; i <= 5; i++) press(32'(i), 1'b0);
        check("t3_count", count, 4);
        check("t3_ovr", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t3_head", data_input, 32'(i));
            pop_one();
        end
        check("t3_empty", is_ready, 0);
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        check("t3_clr_ovr", overrun, 0);
        press(32'h6, 1'b0);
        press(32'h7, 1'b0);
        check("t3_wrap_cnt", count, 2);
        check("t3_wrap_6", data_input, 32'h6);
        pop_one();
        check("t3_wrap_7", data_input, 32'h7);
        pop_one();
        check("t3_wrap_empty", count, 0);

        // 4: push and pop together while full
        for (int i = 8; i <= 11; i++) press(32'(i), 1'b0);
        check("t4_full", count, 4);
        press(32'hC, 1'b1);
        check("t4_cnt_same", count, 4);
        check("t4_no_ovr", overrun, 0);
        for (int i = 9; i <= 12; i++) begin
            check("t4_order", data_input, 32'(i));
            pop_one();
        end
        check("t4_empty", count, 0);

        // 5: rd_ack on empty, then coincident with the first push
        pop_one();
        check("t5_ack_cnt", count, 0);
        check("t5_ack_data", data_input, 32'hC);
        press(32'hD, 1'b1);
        check("t5_push_cnt", count, 1);
        check("t5_push_data", data_input, 32'hD);
        pop_one();

        // 6: asynchronous reset mid-operation, button held through reset
        press(32'h14, 1'b0);
        press(32'h15, 1'b0);
        check("t6_pre_cnt", count, 2);
        @(negedge clk);
        sw = 32'h16;
        #2 rst = 1'b1; btn = 1'b1;
        #1;
        check("t6_rst_ready", is_ready, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_data", data_input, 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(6);
        check("t6_not_yet", is_ready, 0);
        cycles(1);
        check("t6_ready", is_ready, 1);
        check("t6_data", data_input, 32'h16);
        check("t6_count", count, 1);
        btn = 1'b0;
        cycles(8);
        check("t6_single", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_port_ctrl.md
Name: input_port_ctrl

Overview:
Input-device controller that sits directly upstream of the system bus.
- Synchronises and debounces a push-button.
- On each debounced press, captures the switch word into a small FIFO.
- Presents the head word to the bus as data_input, with is_ready as the "device has data" flag (the bus's is_ready[0]).
- The bus pops a word with a one-cycle rd_ack strobe when the CPU reads the input port.

Parameters:
- DW, 32, data width of the switch word and of data_input
- DEPTH, 4, FIFO entries (power of two, ≥2)
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised button must differ from the stable level before the stable level flips (≥2; hardware build uses 1000000)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- btn  input  1  raw push-button, asynchronous to clk
- sw  input  DW  switch word, sampled on the push cycle, held static by the user
- rd_ack  input  1  one-cycle pop strobe from the bus
- clr_ovr  input  1  clears the overrun flag
- is_ready  output  1  FIFO non-empty; drives bus is_ready[0]
- data_input  output  DW  FIFO head word, registered
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- overrun  output  1  sticky: a press was dropped because the FIFO was full

Behaviour:
- One clock; reset is asynchronous and active-high on rst. While rst=1 all state clears:
  - sync FFs = 0, stable = 0, debounce counter = 0
  - FIFO pointers = 0, count = 0, is_ready = 0, data_input = 0, overrun = 0
- Synchroniser: two FFs, btn → s1 → s2.
- Debounce:
  - On each edge where s2 != stable: if cnt == DEBOUNCE_CYCLES-1, then stable <= s2 and cnt <= 0; otherwise cnt++.
  - On any edge where s2 == stable: cnt <= 0.
- Press detect: stable_d registers stable; push = stable & ~stable_d (one cycle per press). Releases generate nothing.
- Latency: btn rises before edge 0 and is held → stable rises after edge DEBOUNCE_CYCLES+1 → FIFO write at edge DEBOUNCE_CYCLES+2 → is_ready=1 after that edge (after edge 6 with default D=4).
- Glitches: any btn pulse shorter than DEBOUNCE_CYCLES cycles at s2 produces no push.
- FIFO:
  - Circular buffer; wr_ptr and rd_ptr wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
  - data_input always shows mem[rd_ptr] and holds its value while empty.
  - is_ready = (count != 0).
- pop = rd_ack & is_ready. rd_ack while empty is ignored: no pointer move, no flag.
- Push cases:
  - count < DEPTH: write sw, wr_ptr++, count++.
  - count == DEPTH and no pop: word dropped, overrun <= 1, FIFO unchanged.
  - push and pop in the same cycle (count ≥ 1): both occur, count unchanged, no overrun even when full. The popped word is the old head.
  - push on empty with rd_ack: only the push takes effect; the new word is popped no earlier than the next cycle.
- Pop timing: after a pop edge, data_input shows the next entry in the following cycle; count decrements; is_ready falls when count reaches 0.
- overrun:
  - Set by a dropped push; cleared by clr_ovr.
  - Set and clear in the same cycle → set wins.
- Reset mid-debounce or mid-FIFO: everything is discarded.
  - If btn is still held high after reset releases, stable starts at 0, so a fresh press is registered after the normal latency.

Test Plan:
1. Reset then single press: D=4, sw=32'h0000_0001, btn high for 20 cycles → is_ready=1 after edge 6 from btn rise, data_input=1, count=1. rd_ack one cycle → is_ready=0, count=0, data_input still 1.
2. Glitch rejection: btn high 3 cycles then low; repeat with 2-cycle bounces → count stays 0, is_ready stays 0. Then btn high 4+ cycles → exactly one push.
3. FIFO order and wrap: five presses with sw = 1, 2, 3, 4, 5 and no rd_ack → count=4, overrun=1, head=1. Pop four times → data_input sequence 1, 2, 3, 4, then is_ready=0. clr_ovr → overrun=0. Two more presses (6, 7) read back as 6, 7 with pointers wrapped.
4. Simultaneous push and pop when full: count=4, rd_ack coincident with the push edge → count stays 4, overrun stays 0, old head popped, new word at tail.
5. rd_ack on empty plus push on empty: rd_ack asserted while count=0 → no change. rd_ack coincident with the first push → count=1, data_input=pushed value.
6. Asynchronous reset mid-operation: count=2, assert rst between clock edges → all outputs 0 immediately. Release rst with btn held high → one new push after DEBOUNCE_CYCLES+2 edges.
